// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, widths and port-grant encoding for the QVGA arbiter.
package fb_pkg;

  localparam int unsigned FB_W     = 320;
  localparam int unsigned FB_H     = 240;
  localparam int unsigned FB_DEPTH = FB_W * FB_H;
  localparam int unsigned ADDR_W   = 17;
  localparam int unsigned DATA_W   = 16;

  typedef logic [ADDR_W-1:0] fb_addr_t;
  typedef logic [DATA_W-1:0] pixel_t;

  typedef struct packed {
    fb_addr_t addr;
    pixel_t   data;
  } fb_wr_t;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } gnt_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Circular-buffer FIFO holding camera writes until the BRAM port is free.
module fb_wr_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_c,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_d;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head_c  = store[rd_ptr];

  // Simultaneous push and pop leaves occupancy unchanged.
  always_comb begin
    count_d = count;
    if (push_ok && !pop_ok) begin
      count_d = count + CNT_W'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage is not reset; occupancy tracking alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/qvga_fb_arbiter.sv
// Single-port frame buffer arbiter: display reads always win, camera writes are
// queued and drained into idle port cycles.
module qvga_fb_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W      = fb_pkg::ADDR_W,
  parameter int unsigned DATA_W      = fb_pkg::DATA_W,
  parameter int unsigned FB_DEPTH    = fb_pkg::FB_DEPTH,
  parameter int unsigned WFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              err_clr,
  output logic [15:0]       drop_cnt,
  output logic              oob_flag
);

  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(WFIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(FB_DEPTH);

  gnt_e               gnt_q;
  gnt_e               gnt_d;
  logic               rd_oob_q;
  logic               rd_oob_c;
  logic               wr_oob_c;
  logic               wr_accept_c;
  logic               push_c;
  logic               pop_c;
  logic [ENTRY_W-1:0] head_c;
  logic [ADDR_W-1:0]  head_addr_c;
  logic [DATA_W-1:0]  head_data_c;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  assign rd_oob_c    = (rd_addr >= ADDR_LIM);
  assign wr_oob_c    = (wr_addr >= ADDR_LIM);
  assign wr_ready    = (fifo_count != CNT_W'(WFIFO_DEPTH));
  assign wr_accept_c = wr_valid && wr_ready;
  assign push_c      = wr_accept_c && !wr_oob_c && !fifo_full;
  assign {head_addr_c, head_data_c} = head_c;

  fb_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (WFIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_c),
    .push_data ({wr_addr, wr_data}),
    .pop       (pop_c),
    .head_c    (head_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q    <= GNT_IDLE;
      rd_oob_q <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      rd_oob_q <= rd_req && rd_oob_c;
    end
  end

  // Grant is decided within the cycle so a display read is never delayed.
  always_comb begin
    gnt_d     = GNT_IDLE;
    pop_c     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset_n) begin
      gnt_d = GNT_IDLE;
    end else if (rd_req) begin
      gnt_d = GNT_RD;
      if (!rd_oob_c) begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
      end
    end else if (!fifo_empty) begin
      gnt_d     = GNT_WR;
      pop_c     = 1'b1;
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = head_addr_c;
      mem_wdata = head_data_c;
    end
  end

  assign rd_valid = (gnt_q == GNT_RD);
  assign rd_data  = (rd_valid && !rd_oob_q) ? mem_rdata : '0;

  // Error bookkeeping; a clear wins over any same-cycle event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
      oob_flag <= 1'b0;
    end else if (err_clr) begin
      drop_cnt <= '0;
      oob_flag <= 1'b0;
    end else begin
      if (wr_valid && !wr_ready && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if ((rd_req && rd_oob_c) || (wr_accept_c && wr_oob_c)) begin
        oob_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qvga_fb_arbiter.sv
// Bench for qvga_fb_arbiter: queue-based port model checked every cycle plus
// directed literal expectations, with a behavioural BRAM behind the port.
module tb_qvga_fb_arbiter;

  localparam int DEPTH = 76800;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_req;
  logic [16:0] rd_addr;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        wr_valid;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        err_clr;
  logic [15:0] drop_cnt;
  logic        oob_flag;

  int checks   = 0;
  int failures = 0;

  logic [15:0] bram   [DEPTH];
  logic [15:0] shadow [DEPTH];

  // model state
  logic [32:0] mq [$];
  bit          pend_v;
  logic [15:0] pend_d;
  int          m_drop;
  bit          m_oob;

  qvga_fb_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .err_clr   (err_clr),
    .drop_cnt  (drop_cnt),
    .oob_flag  (oob_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle model: expected port use from the pending-write queue and inputs.
  always @(negedge clk) begin
    bit          pre_ready;
    bit          rd_in;
    logic [32:0] hd;
    if (!reset_n) begin
      chk("m_rst_rd_valid", 32'(rd_valid), 0);
      chk("m_rst_rd_data",  32'(rd_data), 0);
      chk("m_rst_mem_en",   32'(mem_en), 0);
      chk("m_rst_mem_we",   32'(mem_we), 0);
      chk("m_rst_mem_addr", 32'(mem_addr), 0);
      chk("m_rst_wr_ready", 32'(wr_ready), 1);
      chk("m_rst_drop",     32'(drop_cnt), 0);
      chk("m_rst_oob",      32'(oob_flag), 0);
      mq.delete();
      pend_v = 0; pend_d = 0; m_drop = 0; m_oob = 0;
    end else begin
      rd_in     = (int'(rd_addr) < DEPTH);
      pre_ready = (mq.size() < 4);
      chk("m_rd_valid", 32'(rd_valid), 32'(pend_v));
      chk("m_rd_data",  32'(rd_data), pend_v ? 32'(pend_d) : 0);
      chk("m_wr_ready", 32'(wr_ready), 32'(pre_ready));
      chk("m_drop",     32'(drop_cnt), 32'(m_drop));
      chk("m_oob",      32'(oob_flag), 32'(m_oob));
      if (rd_req) begin
        chk("m_mem_en_rd", 32'(mem_en), 32'(rd_in));
        chk("m_mem_we_rd", 32'(mem_we), 0);
        if (rd_in) chk("m_mem_addr_rd", 32'(mem_addr), 32'(rd_addr));
      end else if (mq.size() > 0) begin
        hd = mq[0];
        chk("m_mem_en_wr",    32'(mem_en), 1);
        chk("m_mem_we_wr",    32'(mem_we), 1);
        chk("m_mem_addr_wr",  32'(mem_addr), 32'(hd[32:16]));
        chk("m_mem_wdata_wr", 32'(mem_wdata), 32'(hd[15:0]));
      end else begin
        chk("m_mem_en_idle", 32'(mem_en), 0);
      end
      // advance the model across the coming rising edge
      pend_v = rd_req;
      pend_d = (rd_req && rd_in) ? shadow[rd_addr] : 16'h0;
      if (!rd_req && mq.size() > 0) begin
        hd = mq.pop_front();
        shadow[hd[32:16]] = hd[15:0];
      end
      if (wr_valid && pre_ready) begin
        if (int'(wr_addr) < DEPTH) mq.push_back({wr_addr, wr_data});
        else m_oob = 1;
      end
      if (wr_valid && !pre_ready && m_drop < 16'hFFFF) m_drop++;
      if (rd_req && !rd_in) m_oob = 1;
      if (err_clr) begin m_drop = 0; m_oob = 0; end
    end
  end

  task automatic drive(input bit rr, input logic [16:0] ra, input bit wv,
                       input logic [16:0] wa, input logic [15:0] wd, input bit ec);
    @(posedge clk); #1;
    rd_req = rr; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd; err_clr = ec;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin bram[i] = 0; shadow[i] = 0; end
    bram[100] = 16'hBEEF; shadow[100] = 16'hBEEF;
    reset_n = 0; rd_req = 0; rd_addr = 0; wr_valid = 0; wr_addr = 0; wr_data = 0; err_clr = 0;
    mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    // single write reaches the port in the next cycle
    drive(0, 0, 1, 17'd5, 16'h1234, 0);
    @(negedge clk); chk("t1_wr_ready", 32'(wr_ready), 1);
    idle();
    @(negedge clk);
    chk("t1_mem_we", 32'(mem_we), 1);
    chk("t1_mem_addr", 32'(mem_addr), 5);
    chk("t1_mem_wdata", 32'(mem_wdata), 32'h1234);

    // reads hog the port: 4 of 6 writes accepted, 2 dropped
    for (int i = 0; i < 10; i++) begin
      drive(1, 17'(i), (i < 6), 17'(10 + i), 16'(16'hA000 + i), 0);
      @(negedge clk);
      chk("t2_mem_we_hold", 32'(mem_we), 0);
      if (i == 4) chk("t2_wr_ready_full", 32'(wr_ready), 0);
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      @(negedge clk);
      chk("t2_drain_we", 32'(mem_we), 1);
      chk("t2_drain_addr", 32'(mem_addr), 32'(10 + i));
      chk("t2_drain_data", 32'(mem_wdata), 32'(16'hA000 + i));
    end
    chk("t2_drop_cnt", 32'(drop_cnt), 2);

    // read latency and data return
    drive(1, 17'd100, 0, 0, 0, 0);
    @(negedge clk); chk("t3_mem_en", 32'(mem_en), 1); chk("t3_mem_addr", 32'(mem_addr), 100);
    idle();
    @(negedge clk); chk("t3_rd_valid", 32'(rd_valid), 1); chk("t3_rd_data", 32'(rd_data), 32'hBEEF);
    idle();
    @(negedge clk); chk("t3_rd_valid_off", 32'(rd_valid), 0); chk("t3_rd_data_off", 32'(rd_data), 0);

    // out-of-range read and write
    drive(1, 17'd76800, 1, 17'd80000, 16'h5555, 0);
    @(negedge clk); chk("t4_mem_en_rd", 32'(mem_en), 0);
    idle();
    @(negedge clk);
    chk("t4_mem_en_wr", 32'(mem_en), 0);
    chk("t4_rd_valid", 32'(rd_valid), 1);
    chk("t4_rd_data", 32'(rd_data), 0);
    chk("t4_oob", 32'(oob_flag), 1);
    drive(0, 0, 0, 0, 0, 1);
    idle();
    @(negedge clk); chk("t4_oob_clr", 32'(oob_flag), 0); chk("t4_drop_clr", 32'(drop_cnt), 0);

    // full FIFO with pop and offered push in the same cycle
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 17'(20 + i), 16'(16'hB000 + i), 0);
    drive(0, 0, 1, 17'd24, 16'hB004, 0);
    @(negedge clk);
    chk("t5_full_ready", 32'(wr_ready), 0);
    chk("t5_pop_addr", 32'(mem_addr), 20);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk); chk("t5_ready_after", 32'(wr_ready), 1); chk("t5_drop", 32'(drop_cnt), 1);
    drive(0, 0, 1, 17'd25, 16'hB005, 0);
    @(negedge clk); chk("t5_pushpop_addr", 32'(mem_addr), 21);
    idle(); @(negedge clk); chk("t5_drain_a", 32'(mem_addr), 22);
    idle(); @(negedge clk); chk("t5_drain_b", 32'(mem_addr), 23);
    idle(); @(negedge clk); chk("t5_drain_c", 32'(mem_addr), 25);
    idle(); @(negedge clk); chk("t5_empty", 32'(mem_en), 0);

    // pointer wrap over 20 sequential writes, then read back
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 17'(i), 16'(16'hC000 + i), 0);
    idle();
    idle();
    for (int i = 0; i <= 20; i++) begin
      drive((i < 20), 17'(i), 0, 0, 0, 0);
      @(negedge clk);
      if (i > 0) chk("t5_readback", 32'(rd_data), 32'(16'hC000 + i - 1));
    end

    // reset with queued writes
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 17'(30 + i), 16'(16'hD000 + i), 0);
    @(posedge clk); #1;
    reset_n = 0; rd_req = 0; wr_valid = 0;
    #1;
    chk("t6_async_wr_ready", 32'(wr_ready), 1);
    chk("t6_async_rd_valid", 32'(rd_valid), 0);
    chk("t6_async_mem_en", 32'(mem_en), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("t6_no_write", 32'(mem_we), 0);
      idle();
    end
    for (int i = 30; i < 33; i++) chk("t6_bram_untouched", 32'(bram[i]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
